fmpadding_axis: RTL and testbench

FMPADDING_AXIS -- requirements
Module: fmpadding_axis

---
 rtl/fmpadding_axis.sv | 104 ++++++++++
 tb/tb_fmpadding_axis.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmpadding_axis.sv
`default_nettype none
// ============================================================================
// fmpadding_axis : zero-pads an NHWC feature-map stream on all four sides
// Rev 1.0
// ============================================================================
module fmpadding_axis #(
  parameter int BIT_WIDTH  = 8,
  parameter int SIMD       = 4,
  parameter int CHANNELS   = 16,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int PAD_LEFT   = 1,
  parameter int PAD_RIGHT  = 1,
  parameter int PAD_TOP    = 1,
  parameter int PAD_BOTTOM = 1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      in0_V_V_TVALID,
  output logic                      in0_V_V_TREADY,
  input  logic [BIT_WIDTH*SIMD-1:0] in0_V_V_TDATA,
  output logic                      out_V_V_TVALID,
  input  logic                      out_V_V_TREADY,
  output logic [BIT_WIDTH*SIMD-1:0] out_V_V_TDATA
);

  localparam int C_CF = CHANNELS / SIMD;
  localparam int C_OW = PAD_LEFT + IMG_W + PAD_RIGHT;
  localparam int C_OH = PAD_TOP + IMG_H + PAD_BOTTOM;
  localparam int C_FW = (C_CF > 1) ? $clog2(C_CF) : 1;
  localparam int C_XW = (C_OW > 1) ? $clog2(C_OW) : 1;
  localparam int C_YW = (C_OH > 1) ? $clog2(C_OH) : 1;
  localparam int C_DW = BIT_WIDTH * SIMD;

  logic [C_FW-1:0] f_q, f_d;
  logic [C_XW-1:0] x_q, x_d;
  logic [C_YW-1:0] y_q, y_d;
  logic [C_DW-1:0] data_q, data_d;
  logic            valid_q, valid_d;

  logic w_pad;
  logic w_load_en;
  logic w_advance;
  int   w_xi;
  int   w_yi;

  // Signed compares keep zero-width pads from collapsing to constant checks.
  always_comb begin
    w_xi  = int'(x_q);
    w_yi  = int'(y_q);
    w_pad = (w_yi < PAD_TOP) || (w_yi >= PAD_TOP + IMG_H) ||
            (w_xi < PAD_LEFT) || (w_xi >= PAD_LEFT + IMG_W);
  end

  assign w_load_en      = !valid_q || out_V_V_TREADY;
  assign in0_V_V_TREADY = !ap_rst && w_load_en && !w_pad;
  assign w_advance      = w_load_en && (w_pad || in0_V_V_TVALID);

  always_comb begin
    f_d     = f_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (w_advance) begin
      data_d  = w_pad ? '0 : in0_V_V_TDATA;
      valid_d = 1'b1;
      if (f_q == C_FW'(C_CF - 1)) begin
        f_d = '0;
        if (x_q == C_XW'(C_OW - 1)) begin
          x_d = '0;
          y_d = (y_q == C_YW'(C_OH - 1)) ? '0 : y_q + C_YW'(1);
        end else begin
          x_d = x_q + C_XW'(1);
        end
      end else begin
        f_d = f_q + C_FW'(1);
      end
    end else if (out_V_V_TREADY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      f_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      f_q     <= f_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_V_V_TVALID = valid_q;
  assign out_V_V_TDATA  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_fmpadding_axis.sv
`default_nettype none
// ============================================================================
// tb_fmpadding_axis : directed self-checking bench for fmpadding_axis
// Rev 1.0
// ============================================================================
module tb_fmpadding_axis;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  int          sel = 0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  always #5 ap_clk = ~ap_clk;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [31:0] a_out_data, b_out_data, c_out_data;
  logic        m_in_ready, m_out_valid;
  logic [31:0] m_out_data;

  // A: 2x2 image, CF=1, one pad per side
  fmpadding_axis #(.BIT_WIDTH(8), .SIMD(4), .CHANNELS(4), .IMG_W(2), .IMG_H(2),
                   .PAD_LEFT(1), .PAD_RIGHT(1), .PAD_TOP(1), .PAD_BOTTOM(1)) u_a (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in0_V_V_TVALID(in_valid && (sel == 0)), .in0_V_V_TREADY(a_in_ready),
    .in0_V_V_TDATA(in_data),
    .out_V_V_TVALID(a_out_valid), .out_V_V_TREADY(out_ready && (sel == 0)),
    .out_V_V_TDATA(a_out_data));

  // B: 3x3 image, CF=2, no padding
  fmpadding_axis #(.BIT_WIDTH(8), .SIMD(4), .CHANNELS(8), .IMG_W(3), .IMG_H(3),
                   .PAD_LEFT(0), .PAD_RIGHT(0), .PAD_TOP(0), .PAD_BOTTOM(0)) u_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in0_V_V_TVALID(in_valid && (sel == 1)), .in0_V_V_TREADY(b_in_ready),
    .in0_V_V_TDATA(in_data),
    .out_V_V_TVALID(b_out_valid), .out_V_V_TREADY(out_ready && (sel == 1)),
    .out_V_V_TDATA(b_out_data));

  // C: 2x2 image, CF=1, two rows of top padding only
  fmpadding_axis #(.BIT_WIDTH(8), .SIMD(4), .CHANNELS(4), .IMG_W(2), .IMG_H(2),
                   .PAD_LEFT(0), .PAD_RIGHT(0), .PAD_TOP(2), .PAD_BOTTOM(0)) u_c (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in0_V_V_TVALID(in_valid && (sel == 2)), .in0_V_V_TREADY(c_in_ready),
    .in0_V_V_TDATA(in_data),
    .out_V_V_TVALID(c_out_valid), .out_V_V_TREADY(out_ready && (sel == 2)),
    .out_V_V_TDATA(c_out_data));

  always_comb begin
    m_in_ready  = a_in_ready;
    m_out_valid = a_out_valid;
    m_out_data  = a_out_data;
    if (sel == 1) begin
      m_in_ready  = b_in_ready;
      m_out_valid = b_out_valid;
      m_out_data  = b_out_data;
    end else if (sel == 2) begin
      m_in_ready  = c_in_ready;
      m_out_valid = c_out_valid;
      m_out_data  = c_out_data;
    end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] in_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          cycles;
  int          first_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Iteration 0 runs immediately so a run started at reset release sees the first edge.
  task automatic run(input int nbeats, input bit toggle, input int max_cyc);
    int          in_idx = 0;
    bit          prev_v = 1'b0;
    bit          prev_r = 1'b0;
    logic [31:0] prev_d = '0;
    got_q.delete();
    cycles   = 0;
    first_in = -1;
    while (got_q.size() < nbeats && cycles < max_cyc) begin
      if (cycles > 0) @(negedge ap_clk);
      in_valid  = (in_idx < in_q.size());
      in_data   = in_valid ? in_q[in_idx] : 32'h0;
      out_ready = toggle ? (cycles % 2 == 0) : 1'b1;
      #1;
      if (prev_v && !prev_r) begin
        check("stall_valid", {31'h0, m_out_valid}, 32'h1);
        check("stall_data", m_out_data, prev_d);
      end
      if (in_valid && m_in_ready) begin
        if (first_in < 0) first_in = cycles;
        in_idx++;
      end
      if (m_out_valid && out_ready) got_q.push_back(m_out_data);
      prev_v = m_out_valid;
      prev_r = out_ready;
      prev_d = m_out_data;
      cycles++;
    end
    if (got_q.size() < nbeats) check("timeout_beats", got_q.size(), nbeats);
  endtask

  task automatic cmp_seq(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_seq"}, (got_q == exp_q) ? 32'h1 : 32'h0, 32'h1);
  endtask

  task automatic do_reset(input int which);
    @(negedge ap_clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ap_rst    = 1'b1;
    sel       = which;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  task automatic load_pad_frame(input int base);
    logic [31:0] pat[16];
    pat = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++)
      exp_q.push_back((pat[i] == 0) ? 32'h0 : pat[i] + base);
  endtask

  initial begin
    // Reset state, with handshake inputs asserted
    sel       = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #7;
    check("rst_valid", {31'h0, m_out_valid}, 32'h0);
    check("rst_data", m_out_data, 32'h0);
    check("rst_in_ready", {31'h0, m_in_ready}, 32'h0);

    // 2x2 padded frame, continuous ready
    do_reset(0);
    in_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    exp_q.delete();
    load_pad_frame(0);
    run(16, 1'b0, 100);
    cmp_seq("pad_cont");
    check("pad_cont_cycles", cycles, 17);
    check("pad_cont_first_in", first_in, 5);

    // Same frame with ready toggling
    do_reset(0);
    run(16, 1'b1, 200);
    cmp_seq("pad_toggle");

    // No padding: pass-through, then output drains
    do_reset(1);
    in_q.delete();
    exp_q.delete();
    for (int i = 0; i < 18; i++) begin
      in_q.push_back(32'hA500_0000 | (32'h0101 * (i + 1)));
      exp_q.push_back(32'hA500_0000 | (32'h0101 * (i + 1)));
    end
    run(18, 1'b0, 100);
    cmp_seq("nopad");
    check("nopad_cycles", cycles, 19);
    check("nopad_first_in", first_in, 0);
    @(negedge ap_clk);
    #1;
    check("nopad_drained", {31'h0, m_out_valid}, 32'h0);

    // Top padding only
    do_reset(2);
    in_q  = '{32'h11, 32'h22, 32'h33, 32'h44};
    exp_q = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44};
    run(8, 1'b0, 100);
    cmp_seq("toppad");
    check("toppad_first_in", first_in, 4);

    // Three frames back to back
    do_reset(0);
    in_q.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) in_q.push_back(i + 1);
    for (int k = 0; k < 3; k++) load_pad_frame(4 * k);
    run(48, 1'b0, 200);
    cmp_seq("frames3");
    check("frames3_cycles", cycles, 49);

    // Reset asserted mid-frame, then a fresh frame
    do_reset(0);
    in_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    run(8, 1'b0, 100);
    check("mid_beat5", (got_q.size() > 5) ? got_q[5] : 32'hDEAD, 32'd1);
    ap_rst   = 1'b1;
    in_valid = 1'b1;
    #1;
    check("mid_rst_valid", {31'h0, m_out_valid}, 32'h0);
    check("mid_rst_data", m_out_data, 32'h0);
    check("mid_rst_in_ready", {31'h0, m_in_ready}, 32'h0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    exp_q.delete();
    load_pad_frame(0);
    run(16, 1'b0, 100);
    cmp_seq("after_rst");
    check("after_rst_first_in", first_in, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
